pin_walk_scanner: RTL and testbench

//  Parametrised board bring-up pattern generator. Walks one active pin across a WIDTH-bit bank at
//  a programmable step rate; all other pins are released (Z) or driven, depending on mode. It sits

---
 rtl/pin_walk_pkg.sv | 30 +++
 rtl/pin_walk_prescaler.sv | 33 +++
 rtl/pin_walk_scanner.sv | 182 ++++++++++++++++++
 tb/tb_pin_walk_scanner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_walk_pkg.sv
// Shared types for the pin walk scanner: mode/direction/state enums and the checkerboard pattern helper.
package pin_walk_pkg;

    localparam int unsigned CHK_MAX_W = 64;

    typedef enum logic [1:0] {
        WALK_LOW     = 2'd0,
        WALK_HIGH    = 2'd1,
        PINGPONG_LOW = 2'd2,
        CHECKER      = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Even positions drive ...1010 (pin 0 low), odd positions the inverse.
    function automatic logic [CHK_MAX_W-1:0] checker_pat(input logic odd);
        logic [CHK_MAX_W-1:0] p;
        p = {(CHK_MAX_W/2){2'b10}};
        return odd ? ~p : p;
    endfunction

endpackage

// File: rtl/pin_walk_prescaler.sv
// Step-rate prescaler: counts 0..div and flags the last cycle of each step period.
module pin_walk_prescaler #(
    parameter int unsigned DIV_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    // div is captured while idle (so the start value is held) and again at every step boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (!en) begin
            cnt   <= '0;
            div_q <= div;
        end else if (cnt == div_q) begin
            cnt   <= '0;
            div_q <= div;
        end else begin
            cnt   <= cnt + DIV_W'(1);
        end
    end

    assign tick = en && (cnt == div_q);

endmodule

// File: rtl/pin_walk_scanner.sv
// Board bring-up pin walker: one active pin swept across a pad bank at a programmable rate.
// Optional pad readback fault checker enabled with `define PIN_WALK_READBACK_EN.
module pin_walk_scanner
    import pin_walk_pkg::*;
#(
    parameter  int unsigned WIDTH = 21,
    parameter  int unsigned DIV_W = 21,
    localparam int unsigned POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic [POS_W-1:0] pos,
    output logic             step,
    output logic             wrap
`ifdef PIN_WALK_READBACK_EN
    ,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             clr,
    output logic [WIDTH-1:0] fault,
    output logic             fault_any
`endif
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);

    state_e           state;
    mode_e            mode_q;
    dir_e             dir;
    logic             tick;

    logic [POS_W-1:0] nxt_pos;
    dir_e             nxt_dir;
    logic             nxt_wrap;
    logic [POS_W-1:0] tgt_pos;
    mode_e            tgt_mode;
    logic [WIDTH-1:0] oe_n;
    logic [WIDTH-1:0] out_n;
    logic [WIDTH-1:0] onehot;
    logic [CHK_MAX_W-1:0] chk;

    pin_walk_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en && (state == ST_RUN)),
        .div   (div),
        .tick  (tick)
    );

    // Next position; ping-pong turns at the far end without repeating end pins.
    always_comb begin
        nxt_pos  = pos;
        nxt_dir  = dir;
        nxt_wrap = 1'b0;
        if (mode_q == PINGPONG_LOW) begin
            if (dir == DIR_UP && pos != LAST_POS) begin
                nxt_pos = pos + POS_W'(1);
            end else begin
                nxt_pos = pos - POS_W'(1);
                nxt_dir = DIR_DOWN;
            end
        end else if (pos == LAST_POS) begin
            nxt_pos = '0;
        end else begin
            nxt_pos = pos + POS_W'(1);
        end
        if (nxt_pos == '0) begin
            nxt_wrap = 1'b1;
            nxt_dir  = DIR_UP;
        end
    end

    // Pattern for the position/mode about to be loaded.
    always_comb begin
        tgt_pos  = nxt_pos;
        tgt_mode = nxt_wrap ? mode_e'(mode) : mode_q;
        if (state == ST_IDLE) begin
            tgt_pos  = '0;
            tgt_mode = mode_e'(mode);
        end
        onehot = WIDTH'(1) << tgt_pos;
        chk    = checker_pat(tgt_pos[0]);
        oe_n   = onehot;
        out_n  = '0;
        case (tgt_mode)
            WALK_HIGH: out_n = onehot;
            CHECKER: begin
                oe_n  = '1;
                out_n = chk[WIDTH-1:0];
            end
            default: out_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mode_q  <= WALK_LOW;
            dir     <= DIR_UP;
            pos     <= '0;
            pin_oe  <= '0;
            pin_out <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
        end else if (!en) begin
            state   <= ST_IDLE;
            dir     <= DIR_UP;
            pos     <= '0;
            pin_oe  <= '0;
            pin_out <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_RUN;
                    mode_q  <= tgt_mode;
                    dir     <= DIR_UP;
                    pos     <= '0;
                    pin_oe  <= oe_n;
                    pin_out <= out_n;
                    step    <= 1'b0;
                    wrap    <= 1'b0;
                end
                default: begin
                    step <= tick;
                    wrap <= tick && nxt_wrap;
                    if (tick) begin
                        pos     <= nxt_pos;
                        dir     <= nxt_dir;
                        pin_oe  <= oe_n;
                        pin_out <= out_n;
                        if (nxt_wrap) begin
                            mode_q <= tgt_mode;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PIN_WALK_READBACK_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] fault_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

    // Short periods are skipped so the pads and synchroniser have settled before sampling.
    always_comb begin
        set_mask = '0;
        if (state == ST_RUN && tick && div >= DIV_W'(3)) begin
            set_mask = pin_oe & (sync2 ^ pin_out);
        end
        fault_n = (clr ? '0 : fault) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault     <= '0;
            fault_any <= 1'b0;
        end else begin
            fault     <= fault_n;
            fault_any <= |fault_n;
        end
    end
`endif

endmodule

// File: tb/tb_pin_walk_scanner.sv
// Directed bench for pin_walk_scanner at WIDTH=5, DIV_W=4 with hand-computed expectations.
module tb_pin_walk_scanner;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] div;
    logic [4:0] pin_out;
    logic [4:0] pin_oe;
    logic [2:0] pos;
    logic       step;
    logic       wrap;
    int         errors;
    int         checks;
`ifdef PIN_WALK_READBACK_EN
    logic [4:0] pin_in;
    logic       clr;
    logic [4:0] fault;
    logic       fault_any;
    logic [4:0] stuck;
    assign pin_in = (pin_out & pin_oe) & ~stuck;
`endif

    pin_walk_scanner #(.WIDTH(5), .DIV_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .div       (div),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .pos       (pos),
        .step      (step),
        .wrap      (wrap)
`ifdef PIN_WALK_READBACK_EN
        ,
        .pin_in    (pin_in),
        .clr       (clr),
        .fault     (fault),
        .fault_any (fault_any)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        div   = 4'd0;
`ifdef PIN_WALK_READBACK_EN
        clr   = 1'b0;
        stuck = 5'b0;
`endif
        #2;
        checks++;
        if (pin_oe !== 5'b0 || pin_out !== 5'b0 || pos !== 3'd0 || step !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset: oe=%b out=%b pos=%0d step=%b wrap=%b, expected all zero", pin_oe, pin_out, pos, step, wrap);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (pin_oe !== 5'b0 || pos !== 3'd0 || step !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: oe=%b pos=%0d step=%b, expected 00000 0 0", pin_oe, pos, step);
        end
    endtask

    task automatic test_walk_low();
        int   p;
        logic es;
        logic ew;
        mode = 2'd0;
        div  = 4'd2;
        en   = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cyc();
            p  = (k / 3) % 5;
            es = (k > 0) && (k % 3 == 0);
            ew = es && (p == 0);
            checks++;
            if (pin_oe !== 5'(1 << p) || pin_out !== 5'b0 || pos !== 3'(p) || step !== es || wrap !== ew) begin
                errors++;
                $display("FAIL walk_low k=%0d: oe=%b out=%b pos=%0d step=%b wrap=%b, expected oe=%b out=00000 pos=%0d step=%b wrap=%b",
                         k, pin_oe, pin_out, pos, step, wrap, 5'(1 << p), p, es, ew);
            end
        end
        en = 1'b0;
        cyc();
    endtask

    task automatic test_pingpong();
        int   seq [11] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
        logic ew;
        mode = 2'd2;
        div  = 4'd0;
        en   = 1'b1;
        for (int k = 0; k < 11; k++) begin
            cyc();
            ew = (k > 0) && (seq[k] == 0);
            checks++;
            if (pos !== 3'(seq[k]) || pin_oe !== 5'(1 << seq[k]) || pin_out !== 5'b0 ||
                step !== (k > 0) || wrap !== ew) begin
                errors++;
                $display("FAIL pingpong k=%0d: pos=%0d oe=%b out=%b step=%b wrap=%b, expected pos=%0d oe=%b out=00000 step=%b wrap=%b",
                         k, pos, pin_oe, pin_out, step, wrap, seq[k], 5'(1 << seq[k]), (k > 0), ew);
            end
        end
        en = 1'b0;
        cyc();
    endtask

    task automatic test_checker_mode_change();
        int         p;
        logic       es;
        logic [4:0] eoe;
        logic [4:0] eout;
        mode = 2'd3;
        div  = 4'd1;
        en   = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc();
            p  = (k / 2) % 5;
            es = (k > 0) && (k % 2 == 0);
            if (k >= 10) begin
                eoe  = 5'(1 << p);
                eout = 5'b00000;
            end else begin
                eoe  = 5'b11111;
                eout = (p % 2 == 0) ? 5'b01010 : 5'b10101;
            end
            checks++;
            if (pin_oe !== eoe || pin_out !== eout || pos !== 3'(p) || step !== es || wrap !== (es && p == 0)) begin
                errors++;
                $display("FAIL checker k=%0d: oe=%b out=%b pos=%0d step=%b wrap=%b, expected oe=%b out=%b pos=%0d step=%b wrap=%b",
                         k, pin_oe, pin_out, pos, step, wrap, eoe, eout, p, es, (es && p == 0));
            end
            if (k == 3) mode = 2'd0;
        end
        en = 1'b0;
        cyc();
    endtask

    task automatic test_en_drop_and_async_reset();
        mode = 2'd0;
        div  = 4'd2;
        en   = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        checks++;
        if (pos !== 3'd3 || pin_oe !== 5'b01000) begin
            errors++;
            $display("FAIL pre_drop: pos=%0d oe=%b, expected pos=3 oe=01000", pos, pin_oe);
        end
        en = 1'b0;
        cyc();
        checks++;
        if (pin_oe !== 5'b0 || pin_out !== 5'b0 || pos !== 3'd0 || step !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: oe=%b out=%b pos=%0d step=%b wrap=%b, expected all zero", pin_oe, pin_out, pos, step, wrap);
        end
        en = 1'b1;
        cyc();
        checks++;
        if (pin_oe !== 5'b00001 || pos !== 3'd0 || step !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL restart: oe=%b pos=%0d step=%b wrap=%b, expected oe=00001 pos=0 step=0 wrap=0", pin_oe, pos, step, wrap);
        end
        cyc();
        cyc();
        cyc();
        checks++;
        if (pos !== 3'd1 || step !== 1'b1 || pin_oe !== 5'b00010) begin
            errors++;
            $display("FAIL restart_step: pos=%0d step=%b oe=%b, expected pos=1 step=1 oe=00010", pos, step, pin_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pin_oe !== 5'b0 || pos !== 3'd0 || step !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: oe=%b pos=%0d step=%b, expected oe=00000 pos=0 step=0", pin_oe, pos, step);
        end
        en = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

`ifdef PIN_WALK_READBACK_EN
    task automatic test_readback();
        stuck = 5'b00100;
        clr   = 1'b0;
        mode  = 2'd1;
        div   = 4'd4;
        en    = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cyc();
            if (k == 9) begin
                checks++;
                if (fault !== 5'b0 || fault_any !== 1'b0) begin
                    errors++;
                    $display("FAIL readback_early: fault=%b any=%b, expected 00000 0", fault, fault_any);
                end
            end
        end
        checks++;
        if (fault !== 5'b00100 || fault_any !== 1'b1) begin
            errors++;
            $display("FAIL readback_set: fault=%b any=%b, expected 00100 1", fault, fault_any);
        end
        en = 1'b0;
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (fault !== 5'b0 || fault_any !== 1'b0) begin
            errors++;
            $display("FAIL readback_clr: fault=%b any=%b, expected 00000 0", fault, fault_any);
        end
        div = 4'd1;
        en  = 1'b1;
        for (int k = 0; k < 25; k++) cyc();
        checks++;
        if (fault !== 5'b0 || fault_any !== 1'b0) begin
            errors++;
            $display("FAIL readback_short_div: fault=%b any=%b, expected 00000 0", fault, fault_any);
        end
        en    = 1'b0;
        stuck = 5'b0;
        cyc();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_walk_low();
        test_pingpong();
        test_checker_mode_change();
        test_en_drop_and_async_reset();
`ifdef PIN_WALK_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
